// File: rtl/nes_pad_responder.sv
// nes_pad_responder
//   Pad-side end of the NES serial joypad protocol, behaving like a CD4021
//   shift register. While the host holds latch high the button levels are
//   sampled; each host nes_clk rising edge then shifts one bit out on
//   data_out (active-low, A first).
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   latch_in    host latch pin (asynchronous to clk)
//   nes_clk_in  host shift clock pin (asynchronous to clk)
//   buttons     pressed=1, {right,left,down,up,start,select,B,A}
//   turbo_en    (NES_PAD_TURBO_EN only) bit0 = turbo A, bit1 = turbo B
//   data_out    serial data, 0 = pressed
//   frame_done  one-cycle pulse after the 8th bit has been shifted
//   bit_index   shifts completed in the current frame, 0..8
//
// Build option
//   NES_PAD_TURBO_EN  adds turbo_en and the frame/phase turbo logic.
module nes_pad_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TURBO_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       latch_in,
  input  logic       nes_clk_in,
  input  logic [7:0] buttons,
`ifdef NES_PAD_TURBO_EN
  input  logic [1:0] turbo_en,
`endif
  output logic       data_out,
  output logic       frame_done,
  output logic [3:0] bit_index
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD     = 2'd1;
  localparam logic [1:0] LATCHED  = 2'd2;
  localparam logic [1:0] SHIFTING = 2'd3;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [7:0]    sr;
  logic [7:0]    load_val;
  logic [7:0]    shift_val;
  logic [TW-1:0] tcnt;

  logic latch_s1, latch_s2, latch_h;
  logic nclk_s1, nclk_s2, nclk_h;
  logic latch_rise, clk_rise;

  // Two-stage synchronisers plus a history stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_s1 <= 1'b0;
      latch_s2 <= 1'b0;
      latch_h  <= 1'b0;
      nclk_s1  <= 1'b0;
      nclk_s2  <= 1'b0;
      nclk_h   <= 1'b0;
    end else begin
      latch_s1 <= latch_in;
      latch_s2 <= latch_s1;
      latch_h  <= latch_s2;
      nclk_s1  <= nes_clk_in;
      nclk_s2  <= nclk_s1;
      nclk_h   <= nclk_s2;
    end
  end

  assign latch_rise = latch_s2 & ~latch_h;
  assign clk_rise   = nclk_s2 & ~nclk_h;

`ifdef NES_PAD_TURBO_EN
  localparam int unsigned FW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(TURBO_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (latch_rise) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // A turbo button reads released during the odd phase.
  always_comb begin
    load_val = ~buttons;
    if (phase && turbo_en[0]) load_val[0] = 1'b1;
    if (phase && turbo_en[1]) load_val[1] = 1'b1;
  end
`else
  assign load_val = ~buttons;
`endif

  assign shift_val = {1'b1, sr[7:1]};

  // Latch rise overrides everything, including a same-cycle nes_clk rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '1;
      bit_index  <= '0;
      frame_done <= 1'b0;
      tcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        state     <= LOAD;
        sr        <= load_val;
        bit_index <= '0;
        tcnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (clk_rise) begin
              sr <= shift_val;
              if (bit_index != 4'd8) bit_index <= bit_index + 4'd1;
            end
          end
          LOAD: begin
            if (latch_s2) begin
              sr <= load_val;
            end else begin
              state <= LATCHED;
              tcnt  <= '0;
            end
          end
          LATCHED: begin
            if (clk_rise) begin
              sr        <= shift_val;
              bit_index <= 4'd1;
              state     <= SHIFTING;
              tcnt      <= '0;
            end else if (tcnt == TIMEOUT_LAST) begin
              state     <= IDLE;
              sr        <= '1;
              bit_index <= '0;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          SHIFTING: begin
            if (clk_rise) begin
              sr        <= shift_val;
              bit_index <= bit_index + 4'd1;
              tcnt      <= '0;
              if (bit_index == 4'd7) begin
                frame_done <= 1'b1;
                state      <= IDLE;
              end
            end else if (tcnt == TIMEOUT_LAST) begin
              state     <= IDLE;
              sr        <= '1;
              bit_index <= '0;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data_out = sr[0];

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder
//   Directed bench for nes_pad_responder. Host timing is scaled down to
//   HP clk cycles per nes_clk half-period so the 100-cycle timeout used
//   here does not fire during normal frames.
module tb_nes_pad_responder;

  localparam int HP = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       latch_in = 1'b0;
  logic       nes_clk_in = 1'b0;
  logic [7:0] buttons = 8'hF7;
`ifdef NES_PAD_TURBO_EN
  logic [1:0] turbo_en = 2'b00;
`endif
  logic       data_out;
  logic       frame_done;
  logic [3:0] bit_index;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  int fd_mark;
  int lrises = 0;
  logic [7:0] bits;

  nes_pad_responder #(
    .TIMEOUT_CYCLES(100)
`ifdef NES_PAD_TURBO_EN
    , .TURBO_FRAMES(1)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .latch_in(latch_in),
    .nes_clk_in(nes_clk_in),
    .buttons(buttons),
`ifdef NES_PAD_TURBO_EN
    .turbo_en(turbo_en),
`endif
    .data_out(data_out),
    .frame_done(frame_done),
    .bit_index(bit_index)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_latch();
    latch_in = 1'b1;
    lrises++;
    tick(2 * HP);
    latch_in = 1'b0;
    tick(HP);
  endtask

  // Sample data_out as the host would at the rising edge, then pulse.
  task automatic pulse(output logic b);
    b = data_out;
    nes_clk_in = 1'b1;
    tick(HP);
    nes_clk_in = 1'b0;
    tick(HP);
  endtask

  task automatic read_frame(input int change_at, input logic [7:0] new_buttons,
                            output logic [7:0] b);
    logic x;
    do_latch();
    for (int k = 0; k < 8; k++) begin
      if (k == change_at) buttons = new_buttons;
      pulse(x);
      b[k] = x;
    end
  endtask

  initial begin
    logic x;
    tick(5);
    reset = 1'b0;
    tick(5);
    check("reset_data", data_out, 1'b1);
    check("reset_idx", bit_index, 4'd0);
    check("reset_fd", frame_done, 1'b0);

    // Start released: serial 0,0,0,1,0,0,0,0
    fd_mark = fd_count;
    read_frame(-1, 8'h00, bits);
    check("frame_bits", bits, 8'h08);
    check("frame_idx", bit_index, 4'd8);
    check("frame_fd", fd_count - fd_mark, 1);

    // Extra pulses past the frame
    fd_mark = fd_count;
    pulse(x);
    check("pulse9_data", x, 1'b1);
    pulse(x);
    check("pulse10_data", x, 1'b1);
    check("pulse10_idx", bit_index, 4'd8);
    check("extra_fd", fd_count - fd_mark, 0);

    // Buttons change mid-shift: current frame unaffected
    buttons = 8'h00;
    read_frame(3, 8'h01, bits);
    check("midshift_bits", bits, 8'hFF);
    read_frame(-1, 8'h01, bits);
    check("next_frame_bits", bits, 8'hFE);

    // Abort by re-latch after 4 clocks, then timeout
    buttons = 8'hF7;
    fd_mark = fd_count;
    do_latch();
    for (int k = 0; k < 4; k++) pulse(x);
    check("abort_idx_before", bit_index, 4'd4);
    latch_in = 1'b1;
    lrises++;
    tick(10);
    check("abort_idx", bit_index, 4'd0);
    check("abort_data", data_out, 1'b0);
    latch_in = 1'b0;
    tick(95);
    check("pre_timeout_data", data_out, 1'b0);
    tick(15);
    check("timeout_data", data_out, 1'b1);
    check("timeout_idx", bit_index, 4'd0);
    check("abort_fd", fd_count - fd_mark, 0);

    // Latch and nes_clk rising together: latch wins
    buttons = 8'h01;
    fd_mark = fd_count;
    latch_in = 1'b1;
    nes_clk_in = 1'b1;
    lrises++;
    tick(10);
    check("same_idx", bit_index, 4'd0);
    check("same_data", data_out, 1'b0);
    tick(50);
    latch_in = 1'b0;
    tick(HP);
    nes_clk_in = 1'b0;
    tick(HP);
    for (int k = 0; k < 8; k++) begin
      pulse(x);
      bits[k] = x;
    end
    check("same_bits", bits, 8'hFE);
    check("same_fd", fd_count - fd_mark, 1);

    // Reset mid-frame
    buttons = 8'hF7;
    do_latch();
    for (int k = 0; k < 3; k++) pulse(x);
    reset = 1'b1;
    tick(1);
    check("midreset_data", data_out, 1'b1);
    check("midreset_idx", bit_index, 4'd0);
    check("midreset_fd", frame_done, 1'b0);
    reset = 1'b0;
    lrises = 0;
    tick(5);
    read_frame(-1, 8'h00, bits);
    check("post_reset_bits", bits, 8'h08);

`ifdef NES_PAD_TURBO_EN
    // TURBO_FRAMES=1: phase equals latch count since reset, mod 2
    buttons = 8'h01;
    turbo_en = 2'b01;
    read_frame(-1, 8'h00, bits);
    check("turbo_frame_a", bits, (lrises % 2) ? 8'hFF : 8'hFE);
    read_frame(-1, 8'h00, bits);
    check("turbo_frame_b", bits, (lrises % 2) ? 8'hFF : 8'hFE);
    turbo_en = 2'b00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Controller-side end of the NES serial pad protocol. Mimics a CD4021-based NES joypad so the host-side `nes_controller` reader can run in closed-loop simulation and FPGA self-test without a physical pad.
- Takes 8 parallel button levels, samples them while the host holds latch high, then shifts them out on `data_out`, one bit per rising edge of the host's `nes_clk`.
- Sits between on-board switches or a test pattern source and the pad connector pins.

Parameters:
- TIMEOUT_CYCLES, 1000000: clk cycles without a host clock edge, while in LATCHED or SHIFTING, before forcing IDLE (20 ms at 50 MHz).
- TURBO_FRAMES, 4: latch frames per turbo toggle; used only when NES_PAD_TURBO_EN is defined.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- latch_in  input  1  host latch pin; asynchronous to clk.
- nes_clk_in  input  1  host shift clock pin; asynchronous to clk.
- buttons  input  8  pressed=1; bit order {right,left,down,up,start,select,B,A}, with A in bit 0.
- data_out  output  1  serial data pin; active-low (0 = pressed).
- frame_done  output  1  one-cycle pulse after the 8th bit has been shifted.
- bit_index  output  4  number of shifts completed in the current frame, 0..8.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Input synchronisation and edge detection:
  - latch_in and nes_clk_in each pass through a 2-FF synchroniser plus a history register.
  - Rise and fall detects come from the 2nd FF versus the history register.
  - A pin change is reflected on data_out exactly 3 clk rising edges later.
- Shift register `sr[7:0]`:
  - Load value: sr <= ~buttons, so sr[0] = ~A.
  - data_out = sr[0], driven from a register with no combinational input path.
  - Shift operation: sr <= {1'b1, sr[7:1]}. Bits after the 8th read 1 (not pressed).
- Reset values: sr=8'hFF, data_out=1, frame_done=0, bit_index=0, state=IDLE, timeout counter=0, synchronisers=0.
- FSM states: IDLE, LOAD, LATCHED, SHIFTING.
  - IDLE: on synced latch rise -> LOAD.
  - LOAD: load sr every cycle while synced latch is high. bit_index=0, so data_out tracks ~A live. On latch fall -> LATCHED, and sr freezes at its last loaded value.
  - LATCHED: data_out = ~A. On nes_clk rise: shift, bit_index=1, -> SHIFTING.
  - SHIFTING: on each nes_clk rise, shift and increment bit_index.
    - When bit_index reaches 8: pulse frame_done the following cycle and -> IDLE.
    - bit_index holds at 8 until the next latch.
- nes_clk falling edges are ignored.
- A nes_clk rise in IDLE shifts sr (giving 1s), saturates bit_index at 8, and never pulses frame_done.
- A latch rise in any state -> LOAD, aborting the frame in progress. No frame_done pulse for the aborted frame.
- If latch and nes_clk rise are detected in the same cycle, latch wins: load, no shift.
- Timeout:
  - The counter runs in LATCHED and SHIFTING, and clears on every nes_clk rise.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, sr=8'hFF, bit_index=0, no frame_done pulse.
- Reset asserted mid-frame returns all state to reset values on the next clk edge.

Optional Feature:
- Macro name: NES_PAD_TURBO_EN.
- When defined:
  - An extra input `turbo_en` (width 2: bit0 controls A, bit1 controls B) is added.
  - A frame counter increments on each latch rise. A phase bit toggles every TURBO_FRAMES latches.
  - While a turbo bit is set and phase=1, the corresponding button is masked to not-pressed at load.
  - The counter and phase reset to 0.
- When undefined: no extra port and no turbo logic; loads use buttons directly.

Test Plan:
- Reset held, then released, with no activity -> data_out=1, bit_index=0, frame_done=0.
- buttons=8'b11110111 (Start released), host sequence: latch 12 us, then 8 clocks at 6 us low / 6 us high -> serial bits on the successive nes_clk rising edges are 0,0,0,1,0,0,0,0; frame_done pulses once; bit_index=8. A bench running `nes_controller` against this block must show every button pressed except Start.
- Change buttons from 8'h00 to 8'h01 mid-shift, after the 3rd clock -> the current frame is unaffected; the next frame's first bit is 0 (A pressed).
- A 9th and 10th nes_clk pulse after the frame -> data_out=1 and bit_index stays 8.
- Latch re-asserted after 4 clocks -> frame aborted, no frame_done pulse, bit_index=0, data_out=~A.
- Latch then no clocks for TIMEOUT_CYCLES (overridden to 100) -> state returns to IDLE with data_out=1; with NES_PAD_TURBO_EN, TURBO_FRAMES=1, turbo_en=2'b01 and A held -> A reads pressed/released on alternating frames.
